// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS MEM stage: control-bit positions, default
// memory depth and the MEM/WB pipeline register layout.
package mem_stage_pkg;

    localparam int REGWRITE_BIT = 1;
    localparam int MEMTOREG_BIT = 0;

    localparam int M_BRANCH_BIT   = 2;
    localparam int M_MEMREAD_BIT  = 1;
    localparam int M_MEMWRITE_BIT = 0;

    localparam int DMEM_WORDS_DEFAULT = 256;

    typedef struct packed {
        logic [1:0]  ctl;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  dest;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, branch resolution outputs and MEM/WB outputs of the MEM stage.
// The master modport is the pipeline side; the slave modport is mem_stage.
interface mem_stage_if;
    logic [1:0]  wb_ctl;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic [31:0] ex_mem_npc;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2;
    logic [4:0]  dest_reg;

    logic        pcsrc;
    logic [31:0] pc_target;
    logic [1:0]  mem_wb_ctl;
    logic [31:0] mem_wb_rdata;
    logic [31:0] mem_wb_alu;
    logic [4:0]  mem_wb_dest;
    logic        misaligned;

    modport master (
        output wb_ctl, branch, memread, memwrite, ex_mem_npc, zero,
               alu_result, rdata2, dest_reg,
        input  pcsrc, pc_target, mem_wb_ctl, mem_wb_rdata, mem_wb_alu,
               mem_wb_dest, misaligned
    );

    modport slave (
        input  wb_ctl, branch, memread, memwrite, ex_mem_npc, zero,
               alu_result, rdata2, dest_reg,
        output pcsrc, pc_target, mem_wb_ctl, mem_wb_rdata, mem_wb_alu,
               mem_wb_dest, misaligned
    );
endinterface

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: combinational read, clocked write that is
// suppressed while reset is high. Contents are never cleared.
module data_memory #(
    parameter int DMEM_WORDS = 256,
    localparam int ADDR_W    = $clog2(DMEM_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [DMEM_WORDS];

    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read sees the pre-edge word, so a same-cycle read+write returns old data.
    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data memory access, branch resolution and MEM/WB register.
// Optional macro MEM_ALIGN_CHECK_EN enables the sticky misalignment check.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_WORDS = DMEM_WORDS_DEFAULT,
    localparam int ADDR_W    = $clog2(DMEM_WORDS)
) (
    input logic        clk,
    input logic        reset,
    mem_stage_if.slave bus
);

    logic [2:0]        m_ctl;
    logic [ADDR_W-1:0] word_idx;
    logic              misalign_hit;
    logic              store_en;
    logic [31:0]       mem_rdata;
    logic [31:0]       load_data;
    mem_wb_t           mem_wb_d;
    mem_wb_t           mem_wb_q;

    always_comb begin
        m_ctl        = {bus.branch, bus.memread, bus.memwrite};
        word_idx     = bus.alu_result[ADDR_W+1:2];
        misalign_hit = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_hit = (m_ctl[M_MEMREAD_BIT] | m_ctl[M_MEMWRITE_BIT]) &&
                       (bus.alu_result[1:0] != 2'b00);
`endif
        store_en  = m_ctl[M_MEMWRITE_BIT] & ~misalign_hit;
        load_data = (m_ctl[M_MEMREAD_BIT] && !misalign_hit) ? mem_rdata : 32'h0;
        mem_wb_d  = '{ctl:   bus.wb_ctl,
                      rdata: load_data,
                      alu:   bus.alu_result,
                      dest:  bus.dest_reg};
    end

    data_memory #(.DMEM_WORDS(DMEM_WORDS)) u_dmem (
        .clk   (clk),
        .reset (reset),
        .we    (store_en),
        .addr  (word_idx),
        .wdata (bus.rdata2),
        .rdata (mem_rdata)
    );

    // IF samples the branch decision in the same cycle.
    assign bus.pcsrc     = m_ctl[M_BRANCH_BIT] & bus.zero;
    assign bus.pc_target = bus.ex_mem_npc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    assign bus.mem_wb_ctl   = mem_wb_q.ctl;
    assign bus.mem_wb_rdata = mem_wb_q.rdata;
    assign bus.mem_wb_alu   = mem_wb_q.alu;
    assign bus.mem_wb_dest  = mem_wb_q.dest;

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned_d;
    logic misaligned_q;

    always_comb begin
        misaligned_d = misaligned_q | misalign_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.misaligned = misaligned_q;
`else
    assign bus.misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a word-array reference model predicts each
// MEM/WB capture; a monitor compares it one cycle after the drive.
module tb_mem_stage;

    typedef struct {
        logic [1:0]  ctl;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic        mis;
    } exp_t;

    logic clk;
    logic reset;
    mem_stage_if bus ();

    mem_stage #(.DMEM_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;
    exp_t exp_q [$];
    logic [31:0] model_mem [256];
    logic model_mis = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    // Called just after a falling edge; predicts the capture at the next rising edge.
    task automatic drive(input logic [1:0] wb, input logic br, input logic rd, input logic wr,
                         input logic [31:0] npc, input logic z, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] dst);
        exp_t e;
        int idx;
        logic bad;
        bus.wb_ctl = wb; bus.branch = br; bus.memread = rd; bus.memwrite = wr;
        bus.ex_mem_npc = npc; bus.zero = z; bus.alu_result = alu;
        bus.rdata2 = wd; bus.dest_reg = dst;
        idx = int'((alu / 4) % 256);
        bad = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        bad = (rd || wr) && (alu % 4 != 0);
`endif
        if (!reset) begin
            e.ctl = wb;
            e.alu = alu;
            e.dest = dst;
            e.rdata = (rd && !bad) ? model_mem[idx] : 32'h0;
            if (wr && !bad) model_mem[idx] = wd;
            if (bad) model_mis = 1'b1;
            e.mis = model_mis;
            exp_q.push_back(e);
        end
        #1;
        check("pcsrc", {31'h0, bus.pcsrc}, {31'h0, br & z});
        check("pc_target", bus.pc_target, npc);
    endtask

    task automatic check_zero_regs(input string tag);
        check({tag, "_ctl"},   {30'h0, bus.mem_wb_ctl}, 32'h0);
        check({tag, "_rdata"}, bus.mem_wb_rdata, 32'h0);
        check({tag, "_alu"},   bus.mem_wb_alu, 32'h0);
        check({tag, "_dest"},  {27'h0, bus.mem_wb_dest}, 32'h0);
        check({tag, "_mis"},   {31'h0, bus.misaligned}, 32'h0);
    endtask

    // Monitor: compares each capture against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mem_wb_ctl",   {30'h0, bus.mem_wb_ctl}, {30'h0, e.ctl});
                check("mem_wb_rdata", bus.mem_wb_rdata, e.rdata);
                check("mem_wb_alu",   bus.mem_wb_alu, e.alu);
                check("mem_wb_dest",  {27'h0, bus.mem_wb_dest}, {27'h0, e.dest});
                check("misaligned",   {31'h0, bus.misaligned}, {31'h0, e.mis});
            end
        end
    end

    initial begin
        logic [31:0] a;
        int budget;
        // Reset asserted with nonzero inputs: registers must read zero before any edge.
        reset = 1'b1;
        bus.wb_ctl = 2'b11; bus.branch = 1'b1; bus.memread = 1'b1; bus.memwrite = 1'b1;
        bus.ex_mem_npc = 32'h1; bus.zero = 1'b1; bus.alu_result = 32'h10;
        bus.rdata2 = 32'h5555_5555; bus.dest_reg = 5'd7;
        #1;
        check_zero_regs("reset0");

        @(negedge clk);
        reset = 1'b0;
        drive(2'b10, 1'b0, 1'b0, 1'b0, 32'h4, 1'b0, 32'hCAFE_0000, 32'h0, 5'd3);

        // Fill memory so every later load has a known expected word.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            drive(2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'(i * 4), $urandom, 5'd0);
        end

        // Store then load the same address on consecutive cycles.
        @(negedge clk); drive(2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0);
        @(negedge clk); drive(2'b11, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h10, 32'h0, 5'd9);

        // Branch taken and not taken.
        @(negedge clk); drive(2'b00, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 32'h0, 32'h0, 5'd0);
        @(negedge clk); drive(2'b00, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 5'd0);

        // Address wrap modulo 1 KiB.
        @(negedge clk); drive(2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h400, 32'h1234, 5'd0);
        @(negedge clk); drive(2'b01, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'd1);

        // Simultaneous read and write returns the old word.
        @(negedge clk); drive(2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h14, 32'hA, 5'd0);
        @(negedge clk); drive(2'b11, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h14, 32'hB, 5'd2);
        @(negedge clk); drive(2'b11, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h14, 32'h0, 5'd2);

        // Randomised traffic over a small address window to force reuse.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a = {$urandom_range(0, 7), 22'h0, 10'($urandom_range(0, 127))};
            if ($urandom_range(0, 15) != 0) a[1:0] = 2'b00;
            drive(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                  1'($urandom), a, $urandom, 5'($urandom));
        end

        // Mid-stream async reset; a store attempted under reset must be dropped.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero_regs("reset1");
        model_mis = 1'b0;
        @(negedge clk);
        drive(2'b11, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h20, 32'hBAD0_BAD0, 5'd4);
        @(negedge clk);
        reset = 1'b0;
        drive(2'b11, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h20, 32'h0, 5'd4);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = {22'h0, 10'($urandom_range(0, 255))};
            a[1:0] = 2'b00;
            drive(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                  1'($urandom), a, $urandom, 5'($urandom));
        end

        @(negedge clk);
        drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access (MEM) stage of the five-stage MIPS pipeline. Consumes the EX/MEM register outputs of the execute stage, performs word loads and stores against an internal data memory, resolves the branch decision (PCSrc) for instruction fetch, and registers the results into the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- DMEM_WORDS, 256: data memory depth in 32-bit words; power of two, 16..4096.
- ADDR_W, log2(DMEM_WORDS): word-index width; derived, not overridden.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears the MEM/WB register immediately.
- wb_ctl  in  2  write-back control from EX/MEM: [1] regwrite, [0] memtoreg.
- branch  in  1  branch instruction in MEM.
- memread  in  1  load in MEM.
- memwrite  in  1  store in MEM.
- ex_mem_npc  in  32  branch target from EX/MEM.
- zero  in  1  ALU zero flag from EX/MEM.
- alu_result  in  32  ALU result; byte address for loads/stores.
- rdata2  in  32  store data.
- dest_reg  in  5  destination register number.
- pcsrc  out  1  branch taken to IF = branch & zero; combinational.
- pc_target  out  32  = ex_mem_npc; combinational.
- mem_wb_ctl  out  2  registered wb_ctl.
- mem_wb_rdata  out  32  registered load data.
- mem_wb_alu  out  32  registered alu_result.
- mem_wb_dest  out  5  registered dest_reg.
- misaligned  out  1  sticky misalignment flag (MEM_ALIGN_CHECK_EN only; else tied 0).

## Operation
- Word index = alu_result[ADDR_W+1:2]; address bits above ADDR_W+1 ignored (addresses wrap modulo DMEM_WORDS*4).
- Load: read is combinational from the memory array; read data = word at index when memread=1, else 32'h0.
- Store: when memwrite=1 and reset=0, word at index <= rdata2 on rising clk edge.
- memread and memwrite both 1: store performed; read data returns the pre-store (old) word.
- Memory contents are not cleared by reset; power-up contents undefined; stores are suppressed while reset is high.
- MEM/WB register: on each rising edge with reset=0 captures {wb_ctl, read data, alu_result, dest_reg}. No stall/flush inputs; one instruction per cycle.
- pcsrc and pc_target are never registered here; IF samples them in the same cycle.

## Timing
- Reset values: mem_wb_ctl=0, mem_wb_rdata=0, mem_wb_alu=0, mem_wb_dest=0, misaligned=0; pcsrc/pc_target follow inputs.
- Reset assertion clears registers without waiting for clk; deassertion mid-stream: first capture on the next rising edge.
- Latency: inputs to mem_wb_* outputs one cycle; pcsrc zero cycles.
- Store then load to same address in consecutive cycles: load sees the stored word (write completes at the edge between them).

## Configuration
- MEM_ALIGN_CHECK_EN defined: access (memread|memwrite) with alu_result[1:0]!=0 suppresses the store, forces read data to 0, and sets misaligned on that edge; misaligned stays 1 until reset.
- Undefined: alu_result[1:0] ignored, accesses proceed to the aligned word, misaligned tied 0.

## Structure
- Shared package: WB control bit positions (REGWRITE_BIT=1, MEMTOREG_BIT=0), M control bit positions (branch=2, memread=1, memwrite=0), default DMEM_WORDS.
- One sub-module: data_memory (parameterised array, async read, sync write, write enable gated by reset). MEM/WB register stays inline in mem_stage.

## Test plan
- Reset: hold reset, drive all inputs nonzero -> all mem_wb_* read 0 with no clock edge; release -> values captured next edge.
- Store/load: sw 32'hDEADBEEF to addr 0x10, next cycle lw 0x10 with wb_ctl=2'b11 -> mem_wb_rdata=32'hDEADBEEF, mem_wb_ctl=2'b11 one cycle after load.
- Branch: branch=1, zero=1, ex_mem_npc=0x40 -> pcsrc=1, pc_target=0x40 same cycle; zero=0 -> pcsrc=0.
- Wrap: DMEM_WORDS=256, store 0x1234 to addr 0x400 -> load addr 0x0 returns 0x1234.
- Read+write same cycle: word 5 holds 0xA, memread=memwrite=1, rdata2=0xB -> mem_wb_rdata=0xA; later load returns 0xB.
- Misalignment (macro on): memwrite to 0x13 -> memory unchanged, misaligned=1 and stays 1 until reset.
